// File: rtl/seq_detect_sched_pkg.sv
// Shared types for the seq_detect_sched slice: scheduler FSM states and the
// Moore "1011" detector state encoding with its next-state helper.
package seq_sched_pkg;

  localparam logic [3:0] PATTERN = 4'b1011;
  localparam int         PAT_LEN = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DRAIN = 2'd2,
    ST_RESP  = 2'd3
  } sched_state_e;

  // Encoding equals the length of the pattern prefix matched so far.
  typedef enum logic [2:0] {
    DET_S0    = 3'd0,
    DET_S1    = 3'd1,
    DET_S10   = 3'd2,
    DET_S101  = 3'd3,
    DET_S1011 = 3'd4
  } det_state_e;

  function automatic det_state_e det_next(input det_state_e cur, input logic b);
    det_state_e nxt;
    case (cur)
      DET_S0:    nxt = (b == PATTERN[3]) ? DET_S1    : DET_S0;
      DET_S1:    nxt = (b == PATTERN[2]) ? DET_S10   : DET_S1;
      DET_S10:   nxt = (b == PATTERN[1]) ? DET_S101  : DET_S0;
      DET_S101:  nxt = (b == PATTERN[0]) ? DET_S1011 : DET_S10;
      DET_S1011: nxt = b ? DET_S1 : DET_S10;
      default:   nxt = DET_S0;
    endcase
    return nxt;
  endfunction

  function automatic logic det_is_match(input det_state_e cur);
    return cur == det_state_e'(3'(PAT_LEN));
  endfunction

endpackage

// File: rtl/seq_detect_sched_moore.sv
// Moore overlapping "1011" detector; match reflects the bits consumed up to
// the previous enabled cycle. clr is synchronous and wins over en.
module seq_1011_moore
  import seq_sched_pkg::*;
(
  input  logic clock,
  input  logic reset_n,
  input  logic clr,
  input  logic en,
  input  logic bit_in,
  output logic match
);

  det_state_e state_q, state_d;

  always_comb begin
    state_d = state_q;
    if (clr) begin
      state_d = DET_S0;
    end else if (en) begin
      state_d = det_next(state_q, bit_in);
    end else begin
      state_d = state_q;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= DET_S0;
    end else begin
      state_q <= state_d;
    end
  end

  assign match = det_is_match(state_q);

endmodule

// File: rtl/seq_detect_sched.sv
// Round-robin scheduler sharing one serial 1011 detector among NUM_REQ requesters.
// Optional SEQ_SCHED_STATS_EN adds a saturating total_matches output.
module seq_detect_sched
  import seq_sched_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 16,
  parameter int CNT_W   = 5,
  localparam int ID_W   = $clog2(NUM_REQ),
  localparam int BC_W   = $clog2(DATA_W)
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      resp_valid,
  input  logic                      resp_ready,
  output logic [ID_W-1:0]           resp_id,
  output logic [CNT_W-1:0]          resp_count,
  output logic                      busy
`ifdef SEQ_SCHED_STATS_EN
  ,
  output logic [15:0]               total_matches
`endif
);

  localparam logic [ID_W:0]    NUM_REQ_W = (ID_W+1)'(NUM_REQ);
  localparam logic [ID_W-1:0]  ID_LAST   = ID_W'(NUM_REQ - 1);
  localparam logic [BC_W-1:0]  BIT_LAST  = BC_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

  sched_state_e      state_q, state_d;
  logic [ID_W-1:0]   ptr_q, ptr_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [BC_W-1:0]   bitcnt_q, bitcnt_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  cnt_next;
  logic              resp_valid_q, resp_valid_d;
  logic [ID_W-1:0]   resp_id_q, resp_id_d;
  logic [CNT_W-1:0]  resp_count_q, resp_count_d;

  logic              grant_found;
  logic [ID_W-1:0]   grant_idx;
  logic [ID_W:0]     cand;
  logic [DATA_W-1:0] grant_word;
  logic              accept;
  logic              det_clr, det_en, det_match;

  // First asserted request at or after the pointer, wrapping around.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = {1'b0, ptr_q} + (ID_W+1)'(i);
      if (cand >= NUM_REQ_W) begin
        cand = cand - NUM_REQ_W;
      end else begin
        cand = cand;
      end
      if (!grant_found && req_valid[cand[ID_W-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = cand[ID_W-1:0];
      end else begin
        grant_found = grant_found;
      end
    end
  end

  always_comb begin
    grant_word = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (grant_idx == ID_W'(k)) begin
        grant_word = req_data[k*DATA_W +: DATA_W];
      end else begin
        grant_word = grant_word;
      end
    end
  end

  assign accept = (state_q == ST_IDLE) && grant_found;

  always_comb begin
    req_ready = '0;
    if (accept) begin
      req_ready[grant_idx] = 1'b1;
    end else begin
      req_ready = '0;
    end
  end

  always_comb begin
    cnt_next = cnt_q;
    if (det_match && (cnt_q != CNT_MAX)) begin
      cnt_next = cnt_q + CNT_W'(1);
    end else begin
      cnt_next = cnt_q;
    end
  end

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    id_d         = id_q;
    shreg_d      = shreg_q;
    bitcnt_d     = bitcnt_q;
    cnt_d        = cnt_q;
    resp_valid_d = resp_valid_q;
    resp_id_d    = resp_id_q;
    resp_count_d = resp_count_q;
    det_clr      = 1'b0;
    det_en       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          shreg_d  = grant_word;
          id_d     = grant_idx;
          ptr_d    = (grant_idx == ID_LAST) ? '0 : grant_idx + ID_W'(1);
          bitcnt_d = '0;
          cnt_d    = '0;
          det_clr  = 1'b1;
          state_d  = ST_SHIFT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        det_en  = 1'b1;
        shreg_d = {shreg_q[DATA_W-2:0], 1'b0};
        cnt_d   = cnt_next;
        if (bitcnt_q == BIT_LAST) begin
          bitcnt_d = '0;
          state_d  = ST_DRAIN;
        end else begin
          bitcnt_d = bitcnt_q + BC_W'(1);
        end
      end
      // The detector output lags by one cycle, so the last bit's match lands here.
      ST_DRAIN: begin
        cnt_d        = cnt_next;
        resp_count_d = cnt_next;
        resp_id_d    = id_q;
        resp_valid_d = 1'b1;
        state_d      = ST_RESP;
      end
      ST_RESP: begin
        if (resp_ready) begin
          resp_valid_d = 1'b0;
          state_d      = ST_IDLE;
        end else begin
          state_d = ST_RESP;
        end
      end
      default: begin
        resp_valid_d = 1'b0;
        state_d      = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      ptr_q        <= '0;
      id_q         <= '0;
      shreg_q      <= '0;
      bitcnt_q     <= '0;
      cnt_q        <= '0;
      resp_valid_q <= 1'b0;
      resp_id_q    <= '0;
      resp_count_q <= '0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      id_q         <= id_d;
      shreg_q      <= shreg_d;
      bitcnt_q     <= bitcnt_d;
      cnt_q        <= cnt_d;
      resp_valid_q <= resp_valid_d;
      resp_id_q    <= resp_id_d;
      resp_count_q <= resp_count_d;
    end
  end

  seq_1011_moore u_det (
    .clock   (clock),
    .reset_n (reset_n),
    .clr     (det_clr),
    .en      (det_en),
    .bit_in  (shreg_q[DATA_W-1]),
    .match   (det_match)
  );

  assign resp_valid = resp_valid_q;
  assign resp_id    = resp_id_q;
  assign resp_count = resp_count_q;
  assign busy       = (state_q != ST_IDLE);

`ifdef SEQ_SCHED_STATS_EN
  logic [15:0] total_q, total_d;
  logic [16:0] total_sum;

  always_comb begin
    total_d   = total_q;
    total_sum = {1'b0, total_q} + 17'(resp_count_q);
    if ((state_q == ST_RESP) && resp_ready) begin
      total_d = total_sum[16] ? 16'hFFFF : total_sum[15:0];
    end else begin
      total_d = total_q;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      total_q <= 16'h0000;
    end else begin
      total_q <= total_d;
    end
  end

  assign total_matches = total_q;
`endif

endmodule

// File: tb/tb_seq_detect_sched.sv
// Self-checking bench for seq_detect_sched: directed cases plus randomized jobs
// checked against a round-robin / sliding-window reference model.
module tb_seq_detect_sched;

  localparam int NUM_REQ = 4;
  localparam int DATA_W  = 16;
  localparam int CNT_W   = 5;
  localparam int ID_W    = 2;

  logic                      clock = 1'b0;
  logic                      reset_n;
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_ready;
  logic                      resp_valid;
  logic                      resp_ready;
  logic [ID_W-1:0]           resp_id;
  logic [CNT_W-1:0]          resp_count;
  logic                      busy;
`ifdef SEQ_SCHED_STATS_EN
  logic [15:0]               total_matches;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  int ptr_m   = 0;
  logic [DATA_W-1:0] word_m [NUM_REQ];

  always #5 clock = ~clock;

  seq_detect_sched #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .req_valid     (req_valid),
    .req_data      (req_data),
    .req_ready     (req_ready),
    .resp_valid    (resp_valid),
    .resp_ready    (resp_ready),
    .resp_id       (resp_id),
    .resp_count    (resp_count),
    .busy          (busy)
`ifdef SEQ_SCHED_STATS_EN
    ,
    .total_matches (total_matches)
`endif
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Count 4-bit windows equal to 1011 in the MSB-first stream.
  function automatic int ref_count(input logic [DATA_W-1:0] w);
    int c = 0;
    logic [3:0] win;
    for (int i = 0; i <= DATA_W - 4; i++) begin
      win = w[DATA_W-1-i -: 4];
      if (win == 4'b1011) c++;
    end
    return c;
  endfunction

  function automatic int pick(input logic [NUM_REQ-1:0] m, input int p);
    for (int i = 0; i < NUM_REQ; i++) begin
      if (m[(p + i) % NUM_REQ]) return (p + i) % NUM_REQ;
    end
    return -1;
  endfunction

  task automatic set_word(input int ch, input logic [DATA_W-1:0] w);
    word_m[ch] = w;
    req_data[ch*DATA_W +: DATA_W] = w;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_ready"}, 32'(req_ready), 32'd0);
    check_eq({tag, "_rvalid"}, 32'(resp_valid), 32'd0);
    check_eq({tag, "_rid"}, 32'(resp_id), 32'd0);
    check_eq({tag, "_rcount"}, 32'(resp_count), 32'd0);
    check_eq({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  // Serve every requester in mask; each response is held `hold` extra cycles.
  task automatic run_batch(input logic [NUM_REQ-1:0] mask, input int hold);
    logic [NUM_REQ-1:0] pend;
    int g, lat;
    pend = mask;
    @(negedge clock);
    req_valid = pend;
    #1;
    while (pend != '0) begin
      g = pick(pend, ptr_m);
      check_eq("grant", 32'(req_ready), 32'(1 << g));
      check_eq("busy_idle", 32'(busy), 32'd0);
      @(negedge clock);
      pend[g] = 1'b0;
      req_valid = pend;
      #1;
      check_eq("busy_shift", 32'(busy), 32'd1);
      check_eq("no_grant_shift", 32'(req_ready), 32'd0);
      lat = 1;
      while (!resp_valid && lat < 64) begin
        @(negedge clock);
        #1;
        lat++;
      end
      check_eq("latency", 32'(lat), 32'(DATA_W + 2));
      check_eq("resp_id", 32'(resp_id), 32'(g));
      check_eq("resp_count", 32'(resp_count), 32'(ref_count(word_m[g])));
      for (int h = 0; h < hold; h++) begin
        @(negedge clock);
        #1;
        check_eq("bp_valid", 32'(resp_valid), 32'd1);
        check_eq("bp_id", 32'(resp_id), 32'(g));
        check_eq("bp_count", 32'(resp_count), 32'(ref_count(word_m[g])));
        check_eq("bp_ready", 32'(req_ready), 32'd0);
      end
      resp_ready = 1'b1;
      @(negedge clock);
      resp_ready = 1'b0;
      #1;
      check_eq("resp_drop", 32'(resp_valid), 32'd0);
      ptr_m = (g + 1) % NUM_REQ;
    end
  endtask

  initial begin
    reset_n    = 1'b0;
    req_valid  = '0;
    req_data   = '0;
    resp_ready = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) word_m[k] = '0;
    #1;
    check_reset_outputs("reset");
    repeat (3) @(negedge clock);
    reset_n = 1'b1;

    // Single job, then overlap and all-ones/all-zeros words.
    set_word(0, 16'hB000);
    run_batch(4'b0001, 0);
    set_word(1, 16'hFFFF);
    set_word(2, 16'hB6DB);
    set_word(3, 16'h0000);
    run_batch(4'b1110, 2);

    // Fairness with all four pending.
    for (int k = 0; k < NUM_REQ; k++) set_word(k, 16'hB000);
    run_batch(4'b1111, 1);
    run_batch(4'b0001, 0);

    // No detector carry across job boundaries.
    set_word(1, 16'h0001);
    run_batch(4'b0010, 0);
    set_word(2, 16'h6000);
    run_batch(4'b0100, 0);

    // Back-pressure with a queued request behind it.
    set_word(3, 16'h2D6B);
    set_word(0, 16'hBBBB);
    run_batch(4'b1001, 5);

    // Idle with no requests.
    repeat (3) begin
      @(negedge clock);
      #1;
      check_eq("idle_ready", 32'(req_ready), 32'd0);
      check_eq("idle_busy", 32'(busy), 32'd0);
    end

    // Randomized jobs.
    for (int t = 0; t < 30; t++) begin
      for (int k = 0; k < NUM_REQ; k++) set_word(k, DATA_W'($urandom));
      run_batch(NUM_REQ'($urandom_range(15, 1)), int'($urandom_range(3, 0)));
    end

    // Reset in the middle of a ch2 job.
    set_word(2, 16'hB6DB);
    @(negedge clock);
    req_valid = 4'b0100;
    #1;
    check_eq("rst_grant", 32'(req_ready), 32'(1 << pick(4'b0100, ptr_m)));
    for (int c = 1; c <= 7; c++) begin
      @(negedge clock);
      req_valid = '0;
    end
    reset_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    @(negedge clock);
    reset_n = 1'b1;
    ptr_m = 0;
    set_word(0, 16'h0B0B);
    set_word(2, 16'hB000);
    run_batch(4'b0101, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1, "timeout");
  end

endmodule
